// File: rtl/exec_unit.sv
// exec_unit: integer execute unit (base ALU, optional multiply/divide).
// Latency: base 1 cycle; MUL* 2; DIV*/REM* XLEN+2 (2 for divide-by-zero or signed overflow).
// Backpressure: one op at a time; result held in DONE until out_ready, in_ready low meanwhile.
// Optional feature macro: EXEC_UNIT_MULDIV_EN enables the multiply/divide datapath.
module exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_is_m,
    input  logic            in_is_sub,
    input  logic            in_is_sra,
    input  logic            in_pass,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    assign accept     = in_valid && in_ready;
    assign out_result = res_q;

    // Base ALU evaluated on the live inputs during the accept cycle
    always_comb begin
        shamt   = in2[SHW-1:0];
        alu_res = '0;
        if (in_pass) begin
            alu_res = in2;
        end else begin
            case (in_op)
                3'd0: alu_res = in_is_sub ? (in1 - in2) : (in1 + in2);
                3'd1: alu_res = in1 << shamt;
                3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
                3'd3: alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
                3'd4: alu_res = in1 ^ in2;
                3'd5: begin
                    if (in_is_sra) alu_res = $signed(in1) >>> shamt;
                    else           alu_res = in1 >> shamt;
                end
                3'd6: alu_res = in1 | in2;
                default: alu_res = in1 & in2;
            endcase
        end
    end

`ifdef EXEC_UNIT_MULDIV_EN
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN);

    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [SHW:0]      cnt_q, cnt_d;
    logic              mul_sa, mul_sb, div_signed;
    logic [2*XLEN-1:0] mul_ea, mul_eb, mul_prod;
    logic [XLEN-1:0]   mul_res, quo_fix, rem_fix, rem_next;
    logic [XLEN:0]     div_shifted;
    logic              div_ge, div_zero, div_ovf, div_early, div_last;

    // Multiplier and divider step, both working on latched operands
    always_comb begin
        mul_sa      = (op_q[1:0] == 2'd1) || (op_q[1:0] == 2'd2);
        mul_sb      = (op_q[1:0] == 2'd1);
        mul_ea      = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
        mul_eb      = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
        mul_prod    = mul_ea * mul_eb;
        mul_res     = (op_q[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        div_signed  = !op_q[0];
        div_zero    = (b_q == '0);
        div_ovf     = div_signed && (a_q == XMIN) && (&b_q);
        div_early   = (cnt_q == '0) && (div_zero || div_ovf);
        div_last    = (cnt_q == CNT_LAST);
        div_shifted = {rem_q, quo_q[XLEN-1]};
        div_ge      = (div_shifted >= {1'b0, dvs_q});
        rem_next    = div_ge ? (div_shifted[XLEN-1:0] - dvs_q) : div_shifted[XLEN-1:0];
        // quotient sign follows operand signs, remainder follows the dividend
        quo_fix     = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
        rem_fix     = (div_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
    end
`endif

    // Next-state logic; flush always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_is_m) state_d = S_DONE;
`ifdef EXEC_UNIT_MULDIV_EN
                    else          state_d = in_op[2] ? S_DIV : S_MUL;
`else
                    else          state_d = S_DONE;
`endif
                end
            end
`ifdef EXEC_UNIT_MULDIV_EN
            S_MUL: state_d = S_DONE;
            S_DIV: if (div_early || div_last) state_d = S_DONE;
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Output decode from the current state
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !flush && !rst;
        out_valid = (state_q == S_DONE);
    end

    // Datapath next values: latch at accept, then multiply or iterate the divider
    always_comb begin
        res_d = res_q;
`ifdef EXEC_UNIT_MULDIV_EN
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
`endif
        if (accept) begin
            res_d = in_is_m ? '0 : alu_res;
`ifdef EXEC_UNIT_MULDIV_EN
            op_d  = in_op;
            a_d   = in1;
            b_d   = in2;
            cnt_d = '0;
            rem_d = '0;
            // divider runs on magnitudes; signs are restored in the fixup cycle
            quo_d = (!in_op[0] && in1[XLEN-1]) ? -in1 : in1;
            dvs_d = (!in_op[0] && in2[XLEN-1]) ? -in2 : in2;
        end else if (state_q == S_MUL) begin
            res_d = mul_res;
        end else if (state_q == S_DIV) begin
            if (div_early) begin
                if (div_zero) res_d = op_q[1] ? a_q : '1;
                else          res_d = op_q[1] ? '0 : a_q;
            end else if (div_last) begin
                res_d = op_q[1] ? rem_fix : quo_fix;
            end else begin
                rem_d = rem_next;
                quo_d = {quo_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
`ifdef EXEC_UNIT_MULDIV_EN
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            res_q <= res_d;
`ifdef EXEC_UNIT_MULDIV_EN
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized scoreboard bench for exec_unit at XLEN=32, plus an XLEN=64 wrap check.
// Latency: expected results and latencies come from an arithmetic reference model.
// Backpressure: out_ready is randomized, with forced stalls for the hold checks.
module tb_exec_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_is_m, in_is_sub, in_is_sra, in_pass;
    logic        flush, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in1, in2, out_result;
    logic        v64, r64, ov64;
    logic [63:0] a64, b64, res64;

    exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_is_m(in_is_m), .in_is_sub(in_is_sub), .in_is_sra(in_is_sra), .in_pass(in_pass),
        .in1(in1), .in2(in2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result)
    );

    exec_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_op(3'd0),
        .in_is_m(1'b0), .in_is_sub(1'b0), .in_is_sra(1'b0), .in_pass(1'b0),
        .in1(a64), .in2(b64), .flush(1'b0), .out_valid(ov64), .out_ready(1'b1),
        .out_result(res64)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;
    int   first_vld = 0;
    bit   prev_vld = 1'b0;
    bit   stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        chk++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference model: results straight from the instruction definitions
    function automatic logic [31:0] model(input bit [2:0] op, input bit m, input bit sub,
                                          input bit sra, input bit pass,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b[4:0]);
        if (!m) begin
            if (pass) return b;
            case (op)
                3'd0: return sub ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                3'd3: return (ua < ub) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return sra ? 32'(sa >>> sh) : a >> sh;
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
`ifdef EXEC_UNIT_MULDIV_EN
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ua; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
                if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return op[1] ? 32'd0 : a;
                if (!op[0]) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return op[1] ? 32'(r) : 32'(q);
            end
        endcase
`else
        return 32'd0;
`endif
    endfunction

    function automatic int exp_lat(input bit [2:0] op, input bit m,
                                   input logic [31:0] a, input logic [31:0] b);
`ifdef EXEC_UNIT_MULDIV_EN
        if (m) begin
            if (!op[2]) return 2;
            if (b == 32'd0) return 2;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
`endif
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op (called at posedge+1); expected result queued before the accept edge
    task automatic issue(input string nm, input bit [2:0] op, input bit m, input bit sub,
                         input bit sra, input bit pass, input logic [31:0] a, input logic [31:0] b);
        int   w;
        exp_t e;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) begin
            check({nm, "_in_ready_wait"}, in_ready, 1);
            return;
        end
        in_valid = 1'b1; in_op = op; in_is_m = m; in_is_sub = sub; in_is_sra = sra;
        in_pass = pass; in1 = a; in2 = b;
        e.res  = model(op, m, sub, sra, pass, a, b);
        e.lat  = exp_lat(op, m, a, b);
        e.acc  = cyc + 1;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // scramble inputs: the unit must work from what it latched
        in_valid = 1'b0; in_op = 3'($urandom); in_is_m = 1'($urandom); in_is_sub = 1'($urandom);
        in_is_sra = 1'($urandom); in_pass = 1'($urandom); in1 = $urandom; in2 = $urandom;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_queue_size", 64'(exp_q.size()), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // Consumer side: randomized out_ready unless a stall is forced
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every presented result with the head of the scoreboard
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!prev_vld) first_vld = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                check({exp_q[0].name, "_result"}, out_result, exp_q[0].res);
                check("busy_in_ready", in_ready, 0);
                if (out_ready === 1'b1) begin
                    check({exp_q[0].name, "_latency"}, 64'(first_vld - exp_q[0].acc + 1),
                          64'(exp_q[0].lat));
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_vld = (out_valid === 1'b1) && (out_ready !== 1'b1);
    end

    initial begin
        #800000;
        err++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [2:0]    op;
        bit          m, sub, sra, pass;
        logic [31:0] a, b;

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_is_m = 1'b0; in_is_sub = 1'b0;
        in_is_sra = 1'b0; in_pass = 1'b0; in1 = '0; in2 = '0; flush = 1'b0;
        v64 = 1'b0; a64 = '0; b64 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // 64-bit wraparound
        v64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd1;
        check("x64_in_ready", r64, 1);
        @(posedge clk); #1;
        v64 = 1'b0;
        check("x64_out_valid", ov64, 1);
        check("x64_add_wrap", res64, 0);

        // directed cases
        issue("add_ovf", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
        issue("sra",     3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h24);
        issue("mulh",    3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("mulhu",   3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("div_neg", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue("rem_neg", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue("divu_by0", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
        issue("div_ovf", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("mul_3x4", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        wait_drain();

        // held result under a stalled consumer
        stall = 1'b1;
        @(posedge clk); #1;
        issue("stall_add", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_held_result", out_result, 32'd11);
        stall = 1'b0;
        wait_drain();

        // flush and reset mid-operation
        for (int k = 0; k < 2; k++) begin
`ifdef EXEC_UNIT_MULDIV_EN
            issue("abort_div", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd7);
            repeat (10) @(posedge clk);
            #1;
`else
            stall = 1'b1;
            @(posedge clk); #1;
            issue("abort_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
            repeat (3) @(posedge clk);
            #1;
`endif
            if (k == 0) flush = 1'b1;
            else        rst = 1'b1;
            #1;
            check("abort_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
            flush = 1'b0; rst = 1'b0; stall = 1'b0;
            exp_q.delete(exp_q.size() - 1);
            #1;
            check("abort_idle_ready", in_ready, 1);
            check("abort_no_valid", out_valid, 0);
            issue("after_abort_add", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
            wait_drain();
        end

        // flush with in_valid in IDLE must not accept
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_is_m = 1'b0; in_pass = 1'b0;
        in1 = 32'd9; in2 = 32'd9;
        #1;
        check("flush_blocks_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("flush_no_accept", out_valid, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            m    = ($urandom_range(0, 2) == 0);
            op   = 3'($urandom_range(0, 7));
            sub  = !m && (op == 3'd0) && 1'($urandom);
            sra  = !m && (op == 3'd5) && 1'($urandom);
            pass = !m && ($urandom_range(0, 9) == 0);
            a    = pick();
            b    = pick();
            if (m && op[2] && $urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issue("rand", op, m, sub, sra, pass, a, b);
        end
        wait_drain();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter: SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept; transfer when in_valid && in_ready at a clk edge.
REQ-007 in_op  input  3  funct3: base ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SRL=5 OR=6 AND=7; M-ext MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7.
REQ-008 in_is_m  input  1  selects the M-ext decoding of in_op.
REQ-009 in_is_sub / in_is_sra / in_pass  input  1 each  ADD→SUB, SRL→SRA, result=in2 (base ops only).
REQ-010 in1, in2  input  XLEN each  operands; shift amount = in2[SHW-1:0].
REQ-011 flush  input  1  abort any in-flight or held operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-014 out_result  output  XLEN  registered result.

Function
REQ-015 FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE) && !flush && !rst.
REQ-016 Operands, op and flags SHALL be latched at acceptance; later input changes ignored.
REQ-017 Base ops and in_pass: IDLE→DONE; out_valid high in first cycle after accept edge (latency 1); arithmetic modulo 2^XLEN, SLT signed, SLTU unsigned, compare results zero-extended.
REQ-018 MUL*: IDLE→MUL→DONE (latency 2); MUL low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of 2*XLEN product with signed×signed, signed×unsigned, unsigned×unsigned.
REQ-019 DIV*/REM*: IDLE→DIV, XLEN restoring iterations plus one sign-fixup cycle, →DONE; latency XLEN+2 (34 at XLEN=32).
REQ-020 Divide by zero: quotient all-ones, remainder = in1; resolved early, latency 2.
REQ-021 Signed overflow (in1 = most-negative, in2 = -1, DIV/REM): quotient = in1, remainder 0; latency 2.
REQ-022 Quotient truncates toward zero; remainder takes dividend's sign.
REQ-023 DONE: out_valid=1, out_result stable until out_ready; DONE→IDLE on out_ready; back-to-back accept no earlier than the cycle after.
REQ-024 flush (any state, any cycle): next state IDLE, out_valid=0, result discarded; flush with in_valid in IDLE → no accept.
REQ-025 Iteration counter SHALL be SHW+1 bits and never wrap within an operation.

Reset
REQ-026 rst high at an edge: state IDLE, out_valid 0, out_result 0, counter 0, latched operands 0; overrides flush and in_valid.
REQ-027 rst mid-operation (MUL/DIV/DONE) SHALL abandon it with no out_valid pulse.
REQ-028 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Configuration
REQ-029 Macro EXEC_UNIT_MULDIV_EN: defined → M-ext ops per REQ-018..022.
REQ-030 Not defined → MUL/DIV states and datapath absent; any in_is_m op completes with latency 1, out_result 0.

Verification
REQ-031 XLEN=32, ADD in1=0x7FFFFFFF in2=1, out_ready=1 → out_valid next cycle, result 0x80000000; SRA in1=0x80000000 in2=0x24 → 0xF8000000.
REQ-032 MULH in1=0xFFFFFFFF in2=0xFFFFFFFF → 0x00000000 at latency 2; MULHU same operands → 0xFFFFFFFE.
REQ-033 DIV in1=-7 in2=2 → 0xFFFFFFFD at latency 34; REM same → 0xFFFFFFFF; DIVU in1=5 in2=0 → 0xFFFFFFFF at latency 2; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
REQ-034 out_ready low 5 cycles after DONE → out_result unchanged, in_ready 0, single transfer on out_ready.
REQ-035 flush at DIV iteration 10, and rst at iteration 10 → IDLE next cycle, no out_valid pulse, next ADD 1+1 → 2.
REQ-036 Build without EXEC_UNIT_MULDIV_EN, MUL 3×4 → out_valid at latency 1, result 0; XLEN=64 ADD 0xFFFFFFFFFFFFFFFF+1 → 0.
